// File: rtl/tile_render_sequencer.sv
// tile_render_sequencer: walks every 8-pixel background span of a frame, fetching then rendering each
module tile_render_sequencer #(
   parameter int TILE_COLS = 32,
   parameter int TILE_ROWS = 30
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       frame_start,
   input  logic [7:0] ppu_ctrl2,
   output logic       fetch_req,
   output logic [4:0] fetch_tile_row,
   output logic [4:0] fetch_tile_col,
   output logic [2:0] fetch_fine_y,
   input  logic       fetch_done,
   output logic       render_start,
   output logic [8:0] vga_start_row,
   output logic [8:0] vga_start_col,
   input  logic       render_busy,
   output logic       frame_busy,
   output logic       frame_done
);
   localparam logic [2:0] S_IDLE    = 3'd0;
   localparam logic [2:0] S_FETCH   = 3'd1;
   localparam logic [2:0] S_START   = 3'd2;
   localparam logic [2:0] S_ARM     = 3'd3;
   localparam logic [2:0] S_WAIT    = 3'd4;
   localparam logic [2:0] S_ADVANCE = 3'd5;
   localparam logic [2:0] S_DONE    = 3'd6;
   localparam logic [4:0] LAST_COL  = 5'(TILE_COLS - 1);
   localparam logic [4:0] LAST_ROW  = 5'(TILE_ROWS - 1);
   logic [2:0] state_q, state_d;
   logic [4:0] row_q, row_d, col_q, col_d;
   logic [2:0] fine_q, fine_d;
   logic [8:0] vrow_q, vrow_d, vcol_q, vcol_d;
   logic       accept, skip, adv, last_col, last_fine, last_row;
   assign accept    = (state_q == S_IDLE) && frame_start;
   assign skip      = (ppu_ctrl2[4:3] == 2'b00);
   assign adv       = (state_q == S_ADVANCE);
   assign last_col  = (col_q == LAST_COL);
   assign last_fine = (fine_q == 3'd7);
   assign last_row  = (row_q == LAST_ROW);
   // next state: one span is FETCH -> START -> ARM -> WAIT -> ADVANCE
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:    state_d = frame_start ? (skip ? S_DONE : S_FETCH) : S_IDLE;
         S_FETCH:   state_d = fetch_done ? S_START : S_FETCH;
         S_START:   state_d = S_ARM;
         S_ARM:     state_d = render_busy ? S_WAIT : S_ARM;
         S_WAIT:    state_d = render_busy ? S_WAIT : S_ADVANCE;
         S_ADVANCE: state_d = (last_col && last_fine && last_row) ? S_DONE : S_FETCH;
         S_DONE:    state_d = S_IDLE;
         default:   state_d = S_IDLE;
      endcase
   end
   // span counters: column fastest, then fine row, then tile row; cleared on an accepted start
   always_comb begin
      col_d  = accept ? 5'd0 : adv ? (last_col ? 5'd0 : col_q + 5'd1) : col_q;
      fine_d = accept ? 3'd0 : (adv && last_col) ? fine_q + 3'd1 : fine_q;
      row_d  = accept ? 5'd0 : (adv && last_col && last_fine) ? (last_row ? 5'd0 : row_q + 5'd1) : row_q;
      vrow_d = {1'b0, row_d, 3'b000} + {6'd0, fine_d};
      vcol_d = {1'b0, col_d, 3'b000};
   end
   // state, counters and the pixel coordinates derived from them
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         row_q   <= '0;
         col_q   <= '0;
         fine_q  <= '0;
         vrow_q  <= '0;
         vcol_q  <= '0;
      end else begin
         state_q <= state_d;
         row_q   <= row_d;
         col_q   <= col_d;
         fine_q  <= fine_d;
         vrow_q  <= vrow_d;
         vcol_q  <= vcol_d;
      end
   end
   assign fetch_req      = (state_q == S_FETCH);
   assign render_start   = (state_q == S_START);
   assign frame_done     = (state_q == S_DONE);
   assign frame_busy     = (state_q != S_IDLE);
   assign fetch_tile_row = row_q;
   assign fetch_tile_col = col_q;
   assign fetch_fine_y   = fine_q;
   assign vga_start_row  = vrow_q;
   assign vga_start_col  = vcol_q;
endmodule

// File: tb/tb_tile_render_sequencer.sv
// tb_tile_render_sequencer: directed checks of span order, per-span timing, skip, reset and full-frame counts
module tb_tile_render_sequencer;
   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       frame_start = 1'b0;
   logic [7:0] ppu_ctrl2 = 8'h18;
   logic       fetch_req, fetch_done, render_start, render_busy, frame_busy, frame_done;
   logic [4:0] fetch_tile_row, fetch_tile_col;
   logic [2:0] fetch_fine_y;
   logic [8:0] vga_start_row, vga_start_col;
   int         total = 0;
   int         bad = 0;
   int         fd = 3;
   int         blen = 8;
   int         fcnt = 0;
   int         bcnt = 0;
   logic       mon_clr = 1'b0;
   logic       prev_req = 1'b0;
   int         n_start = 0, n_done = 0, n_fetch = 0, viol = 0;
   logic [8:0]  rec_row  [0:7679];
   logic [8:0]  rec_col  [0:7679];
   logic [12:0] rec_tile [0:7679];
   tile_render_sequencer dut (
      .clk(clk), .rst(rst), .frame_start(frame_start), .ppu_ctrl2(ppu_ctrl2),
      .fetch_req(fetch_req), .fetch_tile_row(fetch_tile_row), .fetch_tile_col(fetch_tile_col),
      .fetch_fine_y(fetch_fine_y), .fetch_done(fetch_done), .render_start(render_start),
      .vga_start_row(vga_start_row), .vga_start_col(vga_start_col), .render_busy(render_busy),
      .frame_busy(frame_busy), .frame_done(frame_done)
   );
   always #5 clk = ~clk;
   // load-section model: fetch_done after fd cycles of fetch_req
   always @(posedge clk) fcnt <= (fetch_req && !rst) ? fcnt + 1 : 0;
   assign fetch_done = fetch_req && (fcnt == fd);
   // renderer model: busy for blen cycles starting the cycle after render_start
   always @(posedge clk) begin
      if (rst) bcnt <= 0;
      else if (render_start) bcnt <= blen;
      else if (bcnt != 0) bcnt <= bcnt - 1;
   end
   assign render_busy = (bcnt != 0);
   // monitor: records every span started and counts pulses and protocol violations
   always @(negedge clk) begin
      if (mon_clr) begin
         n_start = 0; n_done = 0; n_fetch = 0; viol = 0; prev_req = 1'b0;
      end else begin
         if (render_start && n_start < 7680) begin
            rec_row[n_start]  = vga_start_row;
            rec_col[n_start]  = vga_start_col;
            rec_tile[n_start] = {fetch_tile_row, fetch_fine_y, fetch_tile_col};
         end
         if (render_start) n_start++;
         if (frame_done) n_done++;
         if (fetch_req && !prev_req) n_fetch++;
         if ((render_start && fetch_req) || (fetch_req && render_busy)) viol++;
         prev_req = fetch_req;
      end
   end
   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
      end
   endtask
   task automatic tick;
      @(negedge clk);
      #1;
   endtask
   task automatic clear_mon;
      mon_clr = 1'b1;
      tick;
      mon_clr = 1'b0;
   endtask
   initial begin
      int t;
      repeat (3) tick;
      rst = 1'b0;
      tick;
      chk("rst_fetch_req", fetch_req, 0);
      chk("rst_render_start", render_start, 0);
      chk("rst_frame_busy", frame_busy, 0);
      chk("rst_frame_done", frame_done, 0);
      chk("rst_vga_row", vga_start_row, 0);
      chk("rst_vga_col", vga_start_col, 0);
      // skip frame
      clear_mon;
      ppu_ctrl2 = 8'h00;
      frame_start = 1'b1;
      tick;
      frame_start = 1'b0;
      chk("skip_done_n1", frame_done, 1);
      chk("skip_busy_n1", frame_busy, 1);
      chk("skip_req_n1", fetch_req, 0);
      tick;
      chk("skip_done_n2", frame_done, 0);
      chk("skip_busy_n2", frame_busy, 0);
      repeat (3) tick;
      chk("skip_n_start", n_start, 0);
      chk("skip_n_fetch", n_fetch, 0);
      chk("skip_n_done", n_done, 1);
      // single-span timing, then reset mid-WAIT
      clear_mon;
      ppu_ctrl2 = 8'h18;
      fd = 3;
      blen = 8;
      frame_start = 1'b1;
      tick;
      frame_start = 1'b0;
      chk("a_req_n1", fetch_req, 1);
      chk("a_busy_n1", frame_busy, 1);
      chk("a_rs_n1", render_start, 0);
      repeat (3) tick;
      chk("a_req_n4", fetch_req, 1);
      chk("a_rs_n4", render_start, 0);
      tick;
      chk("a_rs_n5", render_start, 1);
      chk("a_req_n5", fetch_req, 0);
      chk("a_row_n5", vga_start_row, 0);
      chk("a_col_n5", vga_start_col, 0);
      tick;
      chk("a_rs_n6", render_start, 0);
      repeat (9) tick;
      chk("a_req_n15", fetch_req, 0);
      tick;
      chk("a_req_n16", fetch_req, 1);
      chk("a_tcol_n16", fetch_tile_col, 1);
      chk("a_col_n16", vga_start_col, 8);
      chk("a_row_n16", vga_start_row, 0);
      repeat (8) tick;
      rst = 1'b1;
      tick;
      chk("a_rst_busy", frame_busy, 0);
      chk("a_rst_tcol", fetch_tile_col, 0);
      chk("a_rst_col", vga_start_col, 0);
      tick;
      rst = 1'b0;
      repeat (3) tick;
      chk("a_rst_idle", frame_busy, 0);
      chk("a_rst_req", fetch_req, 0);
      chk("a_rst_no_done", n_done, 0);
      // full frame with ignored starts and a mid-frame ppu_ctrl2 change
      clear_mon;
      ppu_ctrl2 = 8'h08;
      fd = 0;
      blen = 2;
      frame_start = 1'b1;
      tick;
      frame_start = 1'b0;
      chk("b_tile_n1", {fetch_tile_row, fetch_fine_y, fetch_tile_col}, 0);
      t = 0;
      while (!frame_done && t < 60000) begin
         frame_start = (t == 0 || t == 603);
         if (t == 1000) ppu_ctrl2 = 8'h00;
         tick;
         t++;
      end
      frame_start = 1'b0;
      chk("b_frame_cycles", t, 46080);
      chk("b_done_busy", frame_busy, 1);
      tick;
      chk("b_busy_fall", frame_busy, 0);
      chk("b_done_pulse", frame_done, 0);
      repeat (5) tick;
      chk("b_n_start", n_start, 7680);
      chk("b_n_fetch", n_fetch, 7680);
      chk("b_n_done", n_done, 1);
      chk("b_viol", viol, 0);
      chk("b_s0_row", rec_row[0], 0);
      chk("b_s0_col", rec_col[0], 0);
      chk("b_s31_tile", rec_tile[31], {5'd0, 3'd0, 5'd31});
      chk("b_s31_col", rec_col[31], 248);
      chk("b_s32_tile", rec_tile[32], {5'd0, 3'd1, 5'd0});
      chk("b_s32_row", rec_row[32], 1);
      chk("b_s32_col", rec_col[32], 0);
      chk("b_s255_tile", rec_tile[255], {5'd0, 3'd7, 5'd31});
      chk("b_s255_row", rec_row[255], 7);
      chk("b_s256_tile", rec_tile[256], {5'd1, 3'd0, 5'd0});
      chk("b_s256_row", rec_row[256], 8);
      chk("b_s7679_tile", rec_tile[7679], {5'd29, 3'd7, 5'd31});
      chk("b_s7679_row", rec_row[7679], 239);
      chk("b_s7679_col", rec_col[7679], 248);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
